// File: rtl/spike_aer_encoder_pkg.sv
// Shared definitions for the spike AER encoder: default widths, the
// address-event word layout and a constant-friendly clog2 helper.
package aer_pkg;

    localparam int N_NEURONS_DEF  = 4;
    localparam int ID_W_DEF       = 2;
    localparam int TS_W_DEF       = 8;
    localparam int FIFO_DEPTH_DEF = 4;

    // One address-event word at the default widths: neuron id, then timestamp.
    typedef struct packed {
        logic [ID_W_DEF-1:0] id;
        logic [TS_W_DEF-1:0] ts;
    } aer_event_t;

    // Ceiling log2; usable in parameter and port-width expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/spike_aer_encoder_if.sv
// Valid/ready address-event stream from the encoder towards the IO stage.
interface spike_aer_encoder_if
    import aer_pkg::*;
#(
    parameter int ID_W = ID_W_DEF,
    parameter int TS_W = TS_W_DEF
);

    logic            ev_valid;
    logic            ev_ready;
    logic [ID_W-1:0] ev_id;
    logic [TS_W-1:0] ev_ts;

    // Event producer (the encoder).
    modport master (output ev_valid, ev_id, ev_ts, input ev_ready);

    // Event consumer (the IO stage).
    modport slave (input ev_valid, ev_id, ev_ts, output ev_ready);

endinterface

// File: rtl/spike_aer_encoder_fifo.sv
// Synchronous event FIFO with registered pointers and an occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; the head entry is visible combinationally on o_data.
module spike_event_fifo
    import aer_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_push,
    input  logic [WIDTH-1:0]     i_data,
    input  logic                 i_pop,
    output logic [WIDTH-1:0]     o_data,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [clog2(DEPTH):0] o_count
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Entry storage: written on an accepted push.
    // NOTE: storage has no reset; the count gates every read, so stale data is never observed.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2).
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/spike_aer_encoder.sv
// Spike AER encoder: detects rising edges on the neuron spike levels,
// holds one pending event per neuron, serialises them round-robin into
// an event FIFO and presents {id, ts} words on a valid/ready stream.
// Build option: define AER_TIMESTAMP_EN to carry a free-running timestamp
// with each event; without it ev_ts is tied to 0 and only ids are stored.
module spike_aer_encoder
    import aer_pkg::*;
#(
    parameter int N_NEURONS  = N_NEURONS_DEF,
    parameter int ID_W       = ID_W_DEF,
    parameter int TS_W       = TS_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic [N_NEURONS-1:0]       spike_in,
    spike_aer_encoder_if.master        ev,
    output logic [clog2(FIFO_DEPTH):0] fifo_count,
    input  logic                       clr_overflow,
    output logic                       overflow
);

`ifdef AER_TIMESTAMP_EN
    localparam int DW = ID_W + TS_W;
`else
    localparam int DW = ID_W;
`endif

    logic [N_NEURONS-1:0] r_spike_prev;
    logic [N_NEURONS-1:0] r_pending;
    logic [ID_W-1:0]      r_rr_ptr;
    logic                 r_overflow;

    logic [N_NEURONS-1:0] w_rise;
    logic [N_NEURONS-1:0] w_drain;
    logic [N_NEURONS-1:0] w_drop;
    logic [N_NEURONS-1:0] w_capture;
    logic                 w_grant_valid;
    logic [ID_W-1:0]      w_grant_id;
    logic [ID_W-1:0]      w_rr_next;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [DW-1:0]        w_push_data;
    logic [DW-1:0]        w_head;

    assign w_rise = spike_in & ~r_spike_prev;

    // A rise on a neuron whose previous event is still pending (and not
    // leaving this cycle) is lost; otherwise it becomes pending.
    assign w_drop    = {N_NEURONS{ena}} & w_rise & r_pending & ~w_drain;
    assign w_capture = {N_NEURONS{ena}} & w_rise & ~w_drop;

    // Round-robin pick: first pending neuron at or after r_rr_ptr, wrapping.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_id    = '0;
        // Scan from the far end so the closest candidate is assigned last.
        for (int k = N_NEURONS - 1; k >= 0; k--) begin
            logic [ID_W-1:0] idx;
            idx = ID_W'((int'(r_rr_ptr) + k) % N_NEURONS);
            if (r_pending[idx]) begin
                w_grant_valid = 1'b1;
                w_grant_id    = idx;
            end
        end
    end

    assign w_pop     = ~w_empty & ev.ev_ready;
    assign w_push    = w_grant_valid & (~w_full | w_pop);
    assign w_rr_next = (w_grant_id == ID_W'(N_NEURONS - 1)) ? '0 : w_grant_id + ID_W'(1);

    // One-hot of the pending bit leaving for the FIFO this cycle.
    always_comb begin
        w_drain = '0;
        if (w_push) begin
            w_drain[w_grant_id] = 1'b1;
        end
    end

    // Edge history, pending set/clear, arbitration pointer and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spike_prev <= '0;
            r_pending    <= '0;
            r_rr_ptr     <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_spike_prev <= spike_in;
            r_pending    <= (r_pending & ~w_drain) | w_capture;
            if (w_push) begin
                r_rr_ptr <= w_rr_next;
            end
            if (|w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

`ifdef AER_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts;
    logic [TS_W-1:0] r_pend_ts [N_NEURONS];

    // Free-running timestamp and per-neuron capture of its pre-increment value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                r_pend_ts[i] <= '0;
            end
        end else begin
            if (ena) begin
                r_ts <= r_ts + TS_W'(1);
            end
            for (int i = 0; i < N_NEURONS; i++) begin
                if (w_capture[i]) begin
                    r_pend_ts[i] <= r_ts;
                end
            end
        end
    end

    assign w_push_data = {w_grant_id, r_pend_ts[w_grant_id]};
    assign ev.ev_id    = w_head[DW-1 -: ID_W];
    assign ev.ev_ts    = w_head[TS_W-1:0];
`else
    assign w_push_data = w_grant_id;
    assign ev.ev_id    = w_head;
    assign ev.ev_ts    = TS_W'(0);
`endif

    spike_event_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    assign ev.ev_valid = ~w_empty;
    assign overflow    = r_overflow;

endmodule
